shot_sequencer: RTL and testbench

- Controller downstream of the X-axis flick filter; consumes its spike-magnitude stream and decides when a real shot happened.
- Sequences settle, idle, active and cooldown phases.
- Captures peak magnitude and duration per shot and emits a one-cycle shot event toward the LCD and score logic.
- Rejects glitches (too short) and sustained tilt (too long).

---
 rtl/shot_pkg.sv | 34 +++
 rtl/shot_cooldown_timer.sv | 33 +++
 rtl/shot_sequencer.sv | 161 ++++++++++++++++
 tb/tb_shot_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Shared types and widths for the shot sequencer and its cooldown timer.
package shot_pkg;

  localparam int MAG_W = 16;
  localparam int LEN_W = 8;
  localparam int CNT_W = 8;
  localparam int CD_W  = 24;

  typedef enum logic [1:0] {
    ST_SETTLE   = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } shot_state_e;

  typedef enum logic [1:0] {
    REJ_NONE  = 2'd0,
    REJ_SHORT = 2'd1,
    REJ_TILT  = 2'd2
  } reject_cause_e;

  // Per-sample outcome of the candidate tracker while ACTIVE.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_ACCEPT = 2'd1,
    EV_SHORT  = 2'd2,
    EV_TILT   = 2'd3
  } shot_event_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/shot_cooldown_timer.sv
// Loadable down-counter; done pulses for one cycle when the loaded count has expired.
module shot_cooldown_timer
  import shot_pkg::*;
#(
  parameter int W = CD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;
  logic         running;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - 1'b1;
    end
  end

  assign done = running && (count == '0);

endmodule

// File: rtl/shot_sequencer.sv
// Shot detector on the flick magnitude stream: settle, idle, active, cooldown.
// Optional reject statistics ports are enabled by defining SHOT_SEQ_STATS_EN.
//
// state    | meaning
// SETTLE   | filter baseline converging, samples counted but not evaluated
// IDLE     | waiting for a sample at or above THRESH_ON
// ACTIVE   | candidate in progress, tracking peak and length
// COOLDOWN | dead time after an accepted shot or a tilt abort
module shot_sequencer
  import shot_pkg::*;
#(
  parameter logic [MAG_W-1:0] THRESH_ON      = 16'd200,
  parameter logic [MAG_W-1:0] THRESH_OFF     = 16'd100,
  parameter int unsigned      MIN_SAMPLES    = 2,
  parameter int unsigned      MAX_SAMPLES    = 64,
  parameter int unsigned      SETTLE_SAMPLES = 16,
  parameter logic [CD_W-1:0]  COOLDOWN_CYC   = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flick_valid,
  input  logic [MAG_W-1:0] flick,
  output logic             shot_valid,
  output logic [MAG_W-1:0] shot_peak,
  output logic [LEN_W-1:0] shot_len,
  output logic [CNT_W-1:0] shot_count,
`ifdef SHOT_SEQ_STATS_EN
  output logic [CNT_W-1:0] reject_count,
  output logic [1:0]       last_reject,
`endif
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [LEN_W-1:0] MIN_N    = LEN_W'(MIN_SAMPLES);
  localparam logic [LEN_W:0]   MAX_N    = (LEN_W+1)'(MAX_SAMPLES);
  localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CD_W-1:0]  CD_LOAD  = (COOLDOWN_CYC == '0) ? '0 : COOLDOWN_CYC - 1'b1;

  shot_state_e      state, state_nxt;
  shot_event_e      ev;
  logic [CNT_W-1:0] settle_cnt, settle_nxt;
  logic [MAG_W-1:0] peak, peak_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             cd_load, cd_done;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SETTLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    peak_nxt   = peak;
    len_nxt    = len;
    ev         = EV_NONE;
    if (!enable) begin
      state_nxt  = ST_SETTLE;
      settle_nxt = '0;
      peak_nxt   = '0;
      len_nxt    = '0;
    end else begin
      unique case (state)
        ST_SETTLE: begin
          if (settle_cnt >= SETTLE_N) begin
            state_nxt  = ST_IDLE;
            settle_nxt = '0;
          end else if (flick_valid) begin
            settle_nxt = settle_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (flick_valid && (flick >= THRESH_ON)) begin
            state_nxt = ST_ACTIVE;
            peak_nxt  = flick;
            len_nxt   = LEN_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (flick_valid) begin
            if (flick < THRESH_OFF) begin
              if (len >= MIN_N) begin
                ev        = EV_ACCEPT;
                state_nxt = ST_COOLDOWN;
              end else begin
                ev        = EV_SHORT;
                state_nxt = ST_IDLE;
              end
            // Abort one sample early so len never reaches MAX_SAMPLES.
            end else if (({1'b0, len} + (LEN_W+1)'(2)) >= MAX_N) begin
              ev        = EV_TILT;
              state_nxt = ST_COOLDOWN;
            end else begin
              peak_nxt = (flick > peak) ? flick : peak;
              len_nxt  = len + 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (cd_done) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_SETTLE;
      endcase
    end
  end

  assign cd_load = (ev == EV_ACCEPT) || (ev == EV_TILT);

  shot_cooldown_timer #(.W(CD_W)) u_cooldown (
    .clk      (clk),
    .rst      (rst),
    .clear    (!enable),
    .load     (cd_load),
    .load_val (CD_LOAD),
    .done     (cd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      peak       <= '0;
      len        <= '0;
      shot_valid <= 1'b0;
      shot_peak  <= '0;
      shot_len   <= '0;
      shot_count <= '0;
      busy       <= 1'b0;
    end else begin
      settle_cnt <= settle_nxt;
      peak       <= peak_nxt;
      len        <= len_nxt;
      shot_valid <= (ev == EV_ACCEPT);
      busy       <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_COOLDOWN);
      if (ev == EV_ACCEPT) begin
        shot_peak  <= peak;
        shot_len   <= len;
        shot_count <= shot_count + 1'b1;
      end
    end
  end

`ifdef SHOT_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_count <= '0;
      last_reject  <= REJ_NONE;
    end else if (ev == EV_SHORT) begin
      reject_count <= sat_inc(reject_count);
      last_reject  <= REJ_SHORT;
    end else if (ev == EV_TILT) begin
      reject_count <= sat_inc(reject_count);
      last_reject  <= REJ_TILT;
    end
  end
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed plus randomized bench for shot_sequencer against a candidate-level reference model.
module tb_shot_sequencer;

  localparam int SETTLE_N = 4;
  localparam int CD_N     = 20;
  localparam int MIN_N    = 2;
  localparam int MAX_N    = 8;
  localparam int ON       = 200;
  localparam int OFF      = 100;

  logic        clk = 1'b0;
  logic        rst, enable, flick_valid;
  logic [15:0] flick;
  logic        shot_valid, busy;
  logic [15:0] shot_peak;
  logic [7:0]  shot_len, shot_count;
  logic [1:0]  state_dbg;
`ifdef SHOT_SEQ_STATS_EN
  logic [7:0]  reject_count;
  logic [1:0]  last_reject;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cd_run = 0;
  int cd_last = 0;
  logic prev_sv = 1'b0;
  int exp_peak = 0, exp_len = 0, exp_count = 0, exp_rej = 0, exp_last = 0;

  shot_sequencer #(
    .THRESH_ON      (16'(ON)),
    .THRESH_OFF     (16'(OFF)),
    .MIN_SAMPLES    (MIN_N),
    .MAX_SAMPLES    (MAX_N),
    .SETTLE_SAMPLES (SETTLE_N),
    .COOLDOWN_CYC   (24'(CD_N))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flick_valid  (flick_valid),
    .flick        (flick),
    .shot_valid   (shot_valid),
    .shot_peak    (shot_peak),
    .shot_len     (shot_len),
    .shot_count   (shot_count),
`ifdef SHOT_SEQ_STATS_EN
    .reject_count (reject_count),
    .last_reject  (last_reject),
`endif
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (shot_valid) begin
      pulses++;
      check("sv_single_cycle", 32'(prev_sv), 0);
    end
    prev_sv = shot_valid;
    if (state_dbg == 2'd3) cd_run++;
    else begin
      if (cd_run != 0) cd_last = cd_run;
      cd_run = 0;
    end
  endtask

  task automatic send(input int v, input int gap);
    repeat (gap) tick();
    flick_valid = 1'b1;
    flick       = 16'(v);
    tick();
    flick_valid = 1'b0;
    flick       = '0;
  endtask

  task automatic wait_state(input string tag, input int target);
    int n = 0;
    while (state_dbg !== 2'(target) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(state_dbg), 32'(target));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_peak"},  32'(shot_peak),  32'(exp_peak));
    check({tag, "_len"},   32'(shot_len),   32'(exp_len));
    check({tag, "_count"}, 32'(shot_count), 32'(exp_count));
`ifdef SHOT_SEQ_STATS_EN
    check({tag, "_rejcnt"}, 32'(reject_count), 32'(exp_rej));
    check({tag, "_rejlast"}, 32'(last_reject), 32'(exp_last));
`endif
  endtask

  task automatic settle();
    for (int i = 0; i < SETTLE_N; i++) send(50, $urandom_range(0, 2));
    check("settle_hold", 32'(state_dbg), 0);
    tick();
    check("settle_to_idle", 32'(state_dbg), 1);
  endtask

  task automatic model_accept(input int pk, input int ln);
    exp_peak  = pk;
    exp_len   = ln;
    exp_count = (exp_count + 1) % 256;
  endtask

  task automatic model_reject(input int cause);
`ifdef SHOT_SEQ_STATS_EN
    if (exp_rej < 255) exp_rej++;
    exp_last = cause;
`else
    if (cause < 0) exp_last = 0;
`endif
  endtask

  initial begin
    int s[MAX_N-1];
    int term, last_idx, pk, outcome, extra;

    rst = 1'b1; enable = 1'b1; flick_valid = 1'b0; flick = '0;
    tick();
    tick();
    check("rst_state", 32'(state_dbg), 0);
    check("rst_sv", 32'(shot_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check_outputs("rst");
    rst = 1'b0;
    pulses = 0;
    settle();
    check("settle_busy", 32'(busy), 0);
    check("settle_pulses", 32'(pulses), 0);

    // Basic accepted shot.
    pulses = 0;
    send(250, 0); send(400, 0); send(300, 0); send(80, 0);
    check("acc_sv", 32'(shot_valid), 1);
    check("acc_busy", 32'(busy), 1);
    model_accept(400, 3);
    check_outputs("acc");
    wait_state("acc_idle", 1);
    check("acc_cd_len", 32'(cd_last), CD_N);
    check("acc_pulses", 32'(pulses), 1);

    // Too short: straight back to IDLE.
    pulses = 0;
    send(210, 0); send(90, 0);
    check("short_state", 32'(state_dbg), 1);
    check("short_busy", 32'(busy), 0);
    check("short_pulses", 32'(pulses), 0);
    model_reject(1);
    check_outputs("short");

    // Sustained tilt aborts on the 7th sample.
    pulses = 0;
    for (int i = 0; i < 6; i++) send(300, 0);
    check("tilt_pre_state", 32'(state_dbg), 2);
    send(300, 0);
    check("tilt_state", 32'(state_dbg), 3);
    send(300, 0);
    model_reject(2);
    wait_state("tilt_idle", 1);
    check("tilt_cd_len", 32'(cd_last), CD_N);
    tick();
    check("tilt_stay_idle", 32'(state_dbg), 1);
    check("tilt_pulses", 32'(pulses), 0);
    check_outputs("tilt");

    // THRESH_OFF exactly keeps the candidate; sample during cooldown ignored.
    pulses = 0;
    send(250, 0); send(100, 0); send(150, 0); send(60, 0);
    model_accept(250, 3);
    check_outputs("bound");
    send(200, 2);
    wait_state("bound_idle", 1);
    tick(); tick();
    check("bound_ignored", 32'(state_dbg), 1);
    check("bound_pulses", 32'(pulses), 1);

    // Enable drop mid-ACTIVE.
    pulses = 0;
    send(250, 0); send(300, 0);
    check("en_active", 32'(state_dbg), 2);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("en_state", 32'(state_dbg), 0);
    check("en_busy", 32'(busy), 0);
    check_outputs("en_hold");
    settle();
    check("en_pulses", 32'(pulses), 0);

    // Reset mid-ACTIVE.
    send(250, 0); send(300, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_peak = 0; exp_len = 0; exp_count = 0; exp_rej = 0; exp_last = 0;
    check("rst2_state", 32'(state_dbg), 0);
    check("rst2_busy", 32'(busy), 0);
    check("rst2_sv", 32'(shot_valid), 0);
    check_outputs("rst2");
    settle();
    check("rst2_pulses", 32'(pulses), 0);

    // Randomized candidates against the candidate-level model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: s[0] = ON;
        1: s[0] = 65535;
        default: s[0] = $urandom_range(ON + 1, 5000);
      endcase
      for (int i = 1; i < MAX_N - 1; i++) begin
        if ($urandom_range(0, 3) == 0) s[i] = $urandom_range(0, OFF - 1);
        else if ($urandom_range(0, 4) == 0) s[i] = OFF;
        else s[i] = $urandom_range(OFF, 65535);
      end
      term = -1;
      for (int i = 1; i < MAX_N - 1; i++)
        if (term < 0 && s[i] < OFF) term = i;
      last_idx = (term < 0) ? MAX_N - 2 : term;
      outcome  = (term < 0) ? 2 : ((term >= MIN_N) ? 0 : 1);

      pulses = 0;
      for (int i = 0; i <= last_idx; i++) send(s[i], $urandom_range(0, 3));
      if (outcome == 0) begin
        pk = 0;
        for (int i = 0; i < term; i++) if (s[i] > pk) pk = s[i];
        model_accept(pk, term);
      end else begin
        model_reject(outcome);
      end
      if (outcome == 1) begin
        check("rnd_short_idle", 32'(state_dbg), 1);
      end else begin
        extra = $urandom_range(0, 2);
        for (int k = 0; k < extra; k++) send($urandom_range(ON, 65535), $urandom_range(0, 3));
        wait_state("rnd_idle", 1);
        check("rnd_cd_len", 32'(cd_last), CD_N);
      end
      check("rnd_pulses", 32'(pulses), (outcome == 0) ? 1 : 0);
      check_outputs("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
